// File: rtl/mra_pkg.sv
// Shared constants, AXI encodings and types for the maze routing accelerator fetch path.
package mra_pkg;

    localparam int unsigned DATA_W      = 128;
    localparam int unsigned IDX_W       = 7;
    localparam int unsigned FRAME_ID_W  = 5;
    localparam int unsigned FRAME_BYTES = 2048;
    localparam int unsigned BEATS       = 128;

    // DRAM placement of the two map planes
    localparam logic [31:0] LOC_MAP_BASE = 32'h0001_0000;
    localparam logic [31:0] WGT_MAP_BASE = 32'h0002_0000;

    localparam logic [7:0] LEN_128    = 8'd127;
    localparam logic [2:0] SIZE_16B   = 3'b100;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } beat_t;

endpackage

// File: rtl/mra_beat_reg.sv
// One-entry valid/ready register slice; accepts a new word in the same cycle the held one drains.
module mra_beat_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready_c,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_c = !valid_q || out_ready;
    assign out_valid  = valid_q;
    assign out_data   = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready_c) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mra_frame_fetch.sv
// AXI4 read front end: one 128-beat INCR burst per frame request, re-emitted as a
// backpressurable beat stream with index/last tags and a sticky protocol error flag.
module mra_frame_fetch
    import mra_pkg::*;
#(
    parameter int unsigned            ID_WIDTH    = 4,
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 128,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = ADDR_WIDTH'(mra_pkg::LOC_MAP_BASE),
    parameter int unsigned            FRAME_BYTES = mra_pkg::FRAME_BYTES,
    parameter int unsigned            BEATS       = mra_pkg::BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FRAME_ID_W-1:0] req_frame_id,

    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [7:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,

    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,

    output logic                  done,
    output logic                  err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [IDX_W-1:0]      cnt_q;
    logic                  err_q;

    logic                  slot_ready_c;
    logic                  r_take_c;
    logic                  beat_valid;
    beat_t                 beat_in;
    beat_t                 beat_q;

    // Beat ID is not checked: only one burst is ever outstanding.
    logic                  unused_rid;
    assign unused_rid = ^rid_m_inf;

    // Constant AR attributes; only address and valid vary.
    assign arid_m_inf    = '0;
    assign arlen_m_inf   = LEN_128;
    assign arsize_m_inf  = SIZE_16B;
    assign arburst_m_inf = BURST_INCR;
    assign araddr_m_inf  = araddr_q;

    assign err      = err_q;
    assign out_data = DATA_WIDTH'(beat_q.data);
    assign out_idx  = beat_q.idx;
    assign out_last = beat_q.last;
    assign out_valid = beat_valid;

    assign beat_in = '{
        data: DATA_W'(rdata_m_inf),
        idx:  cnt_q,
        last: (cnt_q == LAST_IDX)
    };

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        arvalid_m_inf = 1'b0;
        rready_m_inf  = 1'b0;
        r_take_c      = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalid_m_inf = 1'b1;
                if (arready_m_inf) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rready_m_inf = slot_ready_c;
                r_take_c     = rvalid_m_inf && slot_ready_c;
                if (r_take_c && (cnt_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat_valid && out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch, beat counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            araddr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && req_valid) begin
                araddr_q <= BASE_ADDR
                          + ADDR_WIDTH'(req_frame_id) * ADDR_WIDTH'(FRAME_BYTES);
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end
            if (r_take_c) begin
                cnt_q <= cnt_q + IDX_W'(1);
                // A bad response or a misplaced rlast flags the frame but never shortens it.
                if ((rresp_m_inf != RESP_OKAY) || (rlast_m_inf != (cnt_q == LAST_IDX))) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    mra_beat_reg #(
        .WIDTH($bits(beat_t))
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (r_take_c),
        .in_ready_c (slot_ready_c),
        .in_data    (beat_in),
        .out_valid  (beat_valid),
        .out_ready  (out_ready),
        .out_data   (beat_q)
    );

endmodule

// File: doc/mra_frame_fetch.md
Name: mra_frame_fetch

Overview:
AXI4 read-master front end for the maze routing accelerator. It accepts a frame request and issues one INCR burst of 128 x 128-bit beats: 64x64 cells x 4 bits = 2 KiB per frame. It re-emits the returned beats as a backpressurable stream into the map SRAM loader. It sits between the MRA request decoder and the DRAM read channels (AR/R).

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 128, AXI data width (only 128 supported)
BASE_ADDR, 32'h0001_0000, DRAM base of frame 0
FRAME_BYTES, 2048, byte stride between frames
BEATS, 128, beats per frame

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  frame request
req_ready  out  1  high only in IDLE
req_frame_id  in  5  frame index 0..31
arid_m_inf  out  ID_WIDTH  constant 0
araddr_m_inf  out  ADDR_WIDTH  burst start address
arlen_m_inf  out  8  constant 8'd127
arsize_m_inf  out  3  constant 3'b100
arburst_m_inf  out  2  constant 2'b01
arvalid_m_inf  out  1  address valid
arready_m_inf  in  1  address ready
rid_m_inf  in  ID_WIDTH  ignored
rdata_m_inf  in  DATA_WIDTH  read data
rresp_m_inf  in  2  response
rlast_m_inf  in  1  last beat
rvalid_m_inf  in  1  data valid
rready_m_inf  out  1  data ready
out_valid  out  1  stream beat valid
out_ready  in  1  consumer ready
out_data  out  DATA_WIDTH  beat payload
out_idx  out  7  beat index 0..127
out_last  out  1  high with idx 127
done  out  1  one-cycle pulse after last beat accepted downstream
err  out  1  sticky error; cleared on next accepted request

Behaviour:
- Clock and reset: single clock clk. Synchronous active-low rst_n, sampled on the rising edge.
- Reset values: all outputs 0, except req_ready=1. State IDLE, beat counter 0, output register empty.
- FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
- IDLE: req_ready=1. On req_valid, latch araddr = BASE_ADDR + frame_id*FRAME_BYTES, clear err, go to ADDR on the next cycle.
  - frame 31 -> 0x0001_F800.
- ADDR: arvalid=1. araddr and all other AR fields are held stable until arready. On arvalid&&arready, go to DATA.
  - arvalid deasserts in the cycle following the handshake.
  - Zero extra latency if arready is already high.
- DATA: single output register stage.
  - rready = !out_valid || out_ready.
  - On rvalid&&rready: register rdata into out_data, out_idx = counter, out_last = (counter==127), out_valid=1, counter++.
  - out_valid clears on out_ready unless refilled in the same cycle. This sustains full throughput, 1 beat/cycle.
- Error checks:
  - rresp != 2'b00 on any beat sets err. The beat is still forwarded.
  - rlast high with counter != 127, or rlast low at counter 127, sets err.
  - In both cases the burst still completes to 128 beats; extra beats after 128 are not accepted.
- After beat 127 is accepted from R, go to DRAIN with rready=0. Wait until out_valid&&out_ready on the last beat, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A req_valid during DONE is not accepted (req_ready=0).
- Counter is 7 bits and wraps to 0 after 127. It is cleared on entering ADDR.
- Simultaneous out_ready and rvalid in DATA: drain and refill happen in the same cycle, with no bubble.
- Reset mid-burst: returns to IDLE in one cycle, drops arvalid, rready and out_valid. The DRAM model must be reset alongside, because outstanding beats are not tracked.
- Latency: first out_valid appears 1 cycle after the first R handshake.

Decomposition:
- Shared package mra_pkg:
  - FRAME_BYTES, BEATS, BASE addresses (location map 0x0001_0000, weight map 0x0002_0000)
  - AXI constants: LEN_128, SIZE_16B, BURST_INCR
  - fetch-state enum
- One natural sub-module: mra_beat_reg, a one-entry valid/ready register slice used for the output stage and reusable elsewhere in MRA.

Test Plan:
- Frame 0, arready high, rvalid every cycle, out_ready=1 -> araddr=0x0001_0000, arlen=127; 128 beats out on consecutive cycles; out_last on idx 127; done pulses 1 cycle after; err=0.
- Frame 31, arready delayed 5 cycles -> arvalid held 6 cycles with araddr=0x0001_F800 stable; then normal burst.
- out_ready toggles 1/0 every cycle, rvalid always 1 -> rready mirrors free slot; no beat lost or duplicated; idx sequence 0..127 intact.
- rlast asserted at beat 100 -> err=1 at beat 100; transfer continues to 128 beats; done still pulses; next request clears err.
- rresp=2'b10 on beat 5 -> err=1; data forwarded unchanged.
- rst_n low for 1 cycle at beat 60 (DRAM model also reset) -> next cycle IDLE, req_ready=1, out_valid=0; new frame 3 request fetches 0x0001_1800 cleanly.
